// File: rtl/inst_fetch_unit.sv
// RV32I instruction-fetch front end: PC, imem request/response sequencing, single-entry decode buffer.
// Optional misaligned-redirect fault handling is enabled by defining FETCH_ALIGN_CHECK_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        fetch_fault
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_FAULT} state_t;
`else
    typedef enum logic [0:0] {S_REQ, S_WAIT} state_t;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and the payload is held stable while valid && !ready
    // (imem_req_addr may change under a stalled request only because of a redirect).

    state_t      state, state_next;
    logic [31:0] pc, pc_next, target;
    logic [31:0] inst_q, inst_pc_q;
    logic        drop, drop_next;
    logic        buf_valid, buf_load, buf_clear;
    logic        req_fire, redirect_en;
    logic        fault_q, fault_next;

    assign imem_req_valid = (state == S_REQ) && !buf_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid     = buf_valid;
    assign inst           = buf_valid ? inst_q : NOP_INST;
    assign inst_pc        = inst_pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target         = redirect_target;
    assign redirect_en    = redirect && (state != S_FAULT);
    assign fetch_fault    = fault_q;
`else
    assign target         = redirect_target & ~32'h0000_0003;
    assign redirect_en    = redirect;
    assign fetch_fault    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        drop_next  = drop;
        fault_next = fault_q;
        buf_load   = 1'b0;
        buf_clear  = buf_valid && inst_ready;

        case (state)
            S_REQ: begin
                if (req_fire) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                    drop_next  = 1'b0;
                    if (!drop) begin
                        buf_load = 1'b1;
                        pc_next  = pc + 32'd4;
                    end
                end
            end
            default: ;
        endcase

        // Redirect flushes the buffer; a request still in flight must have its response dropped.
        if (redirect_en) begin
            buf_load  = 1'b0;
            buf_clear = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_target[1:0] != 2'b00) begin
                fault_next = 1'b1;
                state_next = S_FAULT;
                pc_next    = pc;
                drop_next  = 1'b0;
            end else
`endif
            begin
                pc_next = target;
                if (req_fire || ((state == S_WAIT) && !imem_rsp_valid))
                    drop_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            buf_valid <= 1'b0;
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_PC;
            fault_q   <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            drop    <= drop_next;
            fault_q <= fault_next;
            if (buf_load) begin
                buf_valid <= 1'b1;
                inst_q    <= imem_rsp_data;
                inst_pc_q <= pc;
            end else if (buf_clear) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: scenario tasks plus a scoreboard of {pc, inst} pairs.
// Define FETCH_ALIGN_CHECK_EN on the command line to exercise the misaligned-redirect fault path.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        fetch_fault;

    // second instance for the PC wrap scenario
    logic        w_req_valid, w_req_ready = 1'b0;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = '0;
    logic        w_inst_valid, w_inst_ready = 1'b0;
    logic [31:0] w_inst, w_inst_pc;
    logic        w_fault;

    int tests_run = 0;
    int tests_failed = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_target(redirect_target), .fetch_fault(fetch_fault)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc),
        .redirect(1'b0), .redirect_target(32'h0), .fetch_fault(w_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every consumed instruction must match the oldest expected {pc, inst}.
    task automatic monitor_loop();
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready && !redirect) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_unexpected: got pc=%h inst=%h, required no output", inst_pc, inst);
                end else begin
                    exp = exp_q.pop_front();
                    if ({inst_pc, inst} !== exp) begin
                        tests_failed++;
                        $display("FAIL scoreboard: got pc=%h inst=%h, required pc=%h inst=%h",
                                 inst_pc, inst, exp[63:32], exp[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Waits for a request, accepts it, answers one cycle later; optionally expects it at decode.
    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data, input bit push,
                            output bit ok, output logic [31:0] addr);
        wait_req(ok);
        addr = imem_req_addr;
        if (!ok) return;
        imem_req_ready = 1'b1;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        if (push) exp_q.push_back({exp_pc, data});
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({inst_valid, fetch_fault, inst, inst_pc} !== {1'b0, 1'b0, NOP, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b fault=%b inst=%h pc=%h, required 0 0 %h 0",
                     inst_valid, fetch_fault, inst, inst_pc, NOP);
        end
        rst = 1'b0;
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_request: got valid=%b addr=%h, required 1 00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        bit ok;
        logic [31:0] addr;
        inst_ready = 1'b1;
        do_fetch(32'h0, 32'h0050_0093, 1'b1, ok, addr);
        tests_run++;
        if (!ok || addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL stream_addr0: got ok=%b addr=%h, required 1 00000000", ok, addr);
        end
        tests_run++;
        if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_latency: got inst_valid=%b req_valid=%b, required 1 0", inst_valid, imem_req_valid);
        end
        do_fetch(32'h4, 32'h00A0_0113, 1'b1, ok, addr);
        tests_run++;
        if (!ok || addr !== 32'h4) begin
            tests_failed++;
            $display("FAIL stream_addr4: got ok=%b addr=%h, required 1 00000004", ok, addr);
        end
        wait_req(ok);
        tests_run++;
        if (!ok || imem_req_addr !== 32'h8) begin
            tests_failed++;
            $display("FAIL stream_addr8: got ok=%b addr=%h, required 1 00000008", ok, imem_req_addr);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] addr;
        logic [31:0] data;
        data = $urandom_range(32'h7FFF_FFFF, 0);
        inst_ready = 1'b0;
        do_fetch(32'h8, data, 1'b1, ok, addr);
        tests_run++;
        if (!ok || addr !== 32'h8) begin
            tests_failed++;
            $display("FAIL bp_addr: got ok=%b addr=%h, required 1 00000008", ok, addr);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({inst_valid, imem_req_valid, inst, inst_pc} !== {1'b1, 1'b0, data, 32'h8}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got valid=%b req=%b inst=%h pc=%h, required 1 0 %h 00000008",
                         i, inst_valid, imem_req_valid, inst, inst_pc, data);
            end
            tick();
        end
        inst_ready = 1'b1;
        tick();
        wait_req(ok);
        tests_run++;
        if (!ok || imem_req_addr !== 32'hC) begin
            tests_failed++;
            $display("FAIL bp_next_addr: got ok=%b addr=%h, required 1 0000000c", ok, imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        logic [31:0] addr;
        wait_req(ok);
        imem_req_ready = 1'b1;
        tick();
        redirect = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect = 1'b0;
        tests_run++;
        if (imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rw_no_req: got req_valid=%b, required 0", imem_req_valid);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        tests_run++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h100}) begin
            tests_failed++;
            $display("FAIL rw_stale_drop: got inst_valid=%b req=%b addr=%h, required 0 1 00000100",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        do_fetch(32'h100, 32'h0010_8093, 1'b1, ok, addr);
        tests_run++;
        if (!ok || addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL rw_refetch: got ok=%b addr=%h, required 1 00000100", ok, addr);
        end
    endtask

    task automatic test_redirect_same_cycle();
        bit ok;
        logic [31:0] addr;
        tick();
        wait_req(ok);
        tests_run++;
        if (!ok || imem_req_addr !== 32'h104) begin
            tests_failed++;
            $display("FAIL sc_addr: got ok=%b addr=%h, required 1 00000104", ok, imem_req_addr);
        end
        tick();
        imem_rsp_valid  = 1'b1;
        imem_rsp_data   = 32'h1111_1111;
        redirect        = 1'b1;
        redirect_target = 32'h40;
        tick();
        imem_rsp_valid = 1'b0;
        redirect       = 1'b0;
        tests_run++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h40}) begin
            tests_failed++;
            $display("FAIL sc_rsp_redirect: got inst_valid=%b req=%b addr=%h, required 0 1 00000040",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        inst_ready = 1'b0;
        do_fetch(32'h40, 32'h2222_2222, 1'b0, ok, addr);
        inst_ready      = 1'b1;
        redirect        = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect = 1'b0;
        tests_run++;
        if ({inst_valid, inst, imem_req_valid, imem_req_addr} !== {1'b0, NOP, 1'b1, 32'h40}) begin
            tests_failed++;
            $display("FAIL sc_ready_redirect: got valid=%b inst=%h req=%b addr=%h, required 0 %h 1 00000040",
                     inst_valid, inst, imem_req_valid, imem_req_addr, NOP);
        end
    endtask

    task automatic test_align();
        imem_req_ready  = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        tests_run++;
        if ({fetch_fault, imem_req_valid, inst_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL align_fault: got fault=%b req=%b valid=%b, required 1 0 0",
                     fetch_fault, imem_req_valid, inst_valid);
        end
        imem_req_ready  = 1'b1;
        redirect        = 1'b1;
        redirect_target = 32'h200;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({fetch_fault, imem_req_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL align_sticky: got fault=%b req=%b, required 1 0", fetch_fault, imem_req_valid);
        end
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({fetch_fault, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL align_reset: got fault=%b req=%b addr=%h, required 0 1 00000000",
                     fetch_fault, imem_req_valid, imem_req_addr);
        end
`else
        tests_run++;
        if ({fetch_fault, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h100}) begin
            tests_failed++;
            $display("FAIL align_forced: got fault=%b req=%b addr=%h, required 0 1 00000100",
                     fetch_fault, imem_req_valid, imem_req_addr);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] data;
        data = $urandom_range(32'h0FFF_FFFF, 0);
        imem_req_ready = 1'b0;
        w_req_ready    = 1'b1;
        w_inst_ready   = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_first_addr: got req=%b addr=%h, required 1 fffffffc", w_req_valid, w_req_addr);
        end
        tick();
        w_rsp_valid = 1'b1;
        w_rsp_data  = data;
        tick();
        w_rsp_valid = 1'b0;
        tests_run++;
        if ({w_inst_valid, w_inst_pc, w_inst} !== {1'b1, 32'hFFFF_FFFC, data}) begin
            tests_failed++;
            $display("FAIL wrap_inst: got valid=%b pc=%h inst=%h, required 1 fffffffc %h",
                     w_inst_valid, w_inst_pc, w_inst, data);
        end
        w_inst_ready = 1'b1;
        tick();
        tests_run++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_next_addr: got req=%b addr=%h, required 1 00000000", w_req_valid, w_req_addr);
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_align();
        test_wrap();
        tick();
        tick();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
